// File: rtl/song_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// song_sequencer_pkg
// Purpose : shared field widths, note-ROM word layout, FSM state encoding and
//           the ROM word decoder used by the song sequencer.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package song_sequencer_pkg;

  localparam int OCTAVE_BITS    = 3;
  localparam int NOTE_BITS      = 3;
  localparam int LENGTH_BITS    = 3;
  localparam int FULL_NOTE_BITS = 4;
  localparam int ROM_W          = 12;

  // Note ROM word layout; bit 0 is reserved and never decoded.
  localparam int END_BIT  = 11;
  localparam int REST_BIT = 10;
  localparam int OCT_MSB  = 9;
  localparam int OCT_LSB  = 7;
  localparam int NOTE_MSB = 6;
  localparam int NOTE_LSB = 4;
  localparam int LEN_MSB  = 3;
  localparam int LEN_LSB  = 1;

  localparam logic [NOTE_BITS-1:0] NOTE_INVALID = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic                   is_end;
    logic                   rest;
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] length;
  } rom_word_t;

  // Takes the word without its reserved bit 0, so indices match the layout.
  function automatic rom_word_t decode_word(input logic [ROM_W-1:1] w);
    rom_word_t d;
    d.is_end = w[END_BIT];
    d.rest   = w[REST_BIT];
    d.octave = w[OCT_MSB:OCT_LSB];
    d.note   = w[NOTE_MSB:NOTE_LSB];
    d.length = w[LEN_MSB:LEN_LSB];
    return d;
  endfunction

endpackage

// File: rtl/song_sequencer_gap_timer.sv
// -----------------------------------------------------------------------------
// song_sequencer_gap_timer
// Purpose : loadable down-counter. After a load of N, o_expired goes high in
//           the N-th cycle after the load (N=0: expired in the very next cycle)
//           and stays high until the next load.
// Ports   : i_clk      - clock
//           i_rst_n    - synchronous active-low reset
//           i_load     - load i_load_val into the counter
//           i_load_val - cycles until expiry
//           o_expired  - counter has reached zero
// -----------------------------------------------------------------------------
module song_sequencer_gap_timer
  import song_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Counter: load wins, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
// Purpose : walks the note ROM starting at a song base address and hands one
//           note at a time to the tone generator, with a silent gap between
//           notes. Stops on an end-of-song marker or on i_stop.
// Options : SEQ_LOOP_EN - when defined, an end marker restarts the song from
//           the latched base (pulsing o_done per wrap) instead of finishing.
// Ports   : i_clk, i_rst_n     - clock, synchronous active-low reset
//           i_start            - begin playback at i_song_base (ignored if busy)
//           i_stop             - abort playback (beats start and snd_over)
//           i_song_base        - first ROM address of the song
//           i_full_note        - whole-note duration, latched at start
//           o_rom_addr         - note ROM address (1-cycle read latency)
//           i_rom_data         - note ROM word
//           o_snd_en           - tone generator enable (high for a whole note)
//           o_snd_octave/note/length/full_note - current note fields
//           i_snd_over         - tone generator finished the note
//           o_snd_mute         - buzzer gate (rest, invalid note, gap, idle)
//           o_busy             - high whenever not idle
//           o_done             - one-cycle pulse on normal end of song
// All outputs are registered.
// -----------------------------------------------------------------------------
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int unsigned GAP_CYCLES = 32'd1000000,
  parameter int unsigned OVER_MASK  = 32'd2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic [ADDR_W-1:0]         i_song_base,
  input  logic [FULL_NOTE_BITS-1:0] i_full_note,
  output logic [ADDR_W-1:0]         o_rom_addr,
  input  logic [ROM_W-1:0]          i_rom_data,
  output logic                      o_snd_en,
  output logic [OCTAVE_BITS-1:0]    o_snd_octave,
  output logic [NOTE_BITS-1:0]      o_snd_note,
  output logic [LENGTH_BITS-1:0]    o_snd_length,
  output logic [FULL_NOTE_BITS-1:0] o_snd_full_note,
  input  logic                      i_snd_over,
  output logic                      o_snd_mute,
  output logic                      o_busy,
  output logic                      o_done
);

  // The timers expire in the cycle whose index equals the load value, so the
  // gap loads N-1 to give exactly N silent cycles; a zero gap still gives one.
  localparam logic [31:0] C_GAP_LOAD  = (GAP_CYCLES == 32'd0) ? 32'd0 : (GAP_CYCLES - 32'd1);
  localparam logic [31:0] C_MASK_LOAD = OVER_MASK;

  seq_state_t                r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W-1:0]         r_base;
  logic                      r_en;
  logic [OCTAVE_BITS-1:0]    r_oct;
  logic [NOTE_BITS-1:0]      r_note;
  logic [LENGTH_BITS-1:0]    r_len;
  logic [FULL_NOTE_BITS-1:0] r_full;
  logic                      r_mute;
  logic                      r_busy;
  logic                      r_done;

  seq_state_t                w_next_state;
  logic [ADDR_W-1:0]         w_addr;
  logic [ADDR_W-1:0]         w_base;
  logic                      w_en;
  logic [OCTAVE_BITS-1:0]    w_oct;
  logic [NOTE_BITS-1:0]      w_note;
  logic [LENGTH_BITS-1:0]    w_len;
  logic [FULL_NOTE_BITS-1:0] w_full;
  logic                      w_mute;
  logic                      w_done;
  logic                      w_mask_load;
  logic                      w_gap_load;
  logic                      w_mask_expired;
  logic                      w_gap_expired;
  rom_word_t                 w_word;
  logic                      w_unused_reserved;

  assign w_word            = decode_word(i_rom_data[ROM_W-1:1]);
  assign w_unused_reserved = i_rom_data[0];

  // snd_over is stale-high right after snd_en rises; ignore it for a while.
  song_sequencer_gap_timer #(.CNT_W(32)) u_mask_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_mask_load),
    .i_load_val (C_MASK_LOAD),
    .o_expired  (w_mask_expired)
  );

  song_sequencer_gap_timer #(.CNT_W(32)) u_gap_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_gap_load),
    .i_load_val (C_GAP_LOAD),
    .o_expired  (w_gap_expired)
  );

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    w_next_state = r_state;
    w_addr       = r_addr;
    w_base       = r_base;
    w_en         = 1'b0;
    w_oct        = r_oct;
    w_note       = r_note;
    w_len        = r_len;
    w_full       = r_full;
    w_mute       = 1'b1;
    w_done       = 1'b0;
    w_mask_load  = 1'b0;
    w_gap_load   = 1'b0;

    if (i_stop) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_next_state = ST_FETCH;
            w_addr       = i_song_base;
            w_base       = i_song_base;
            w_full       = i_full_note;
          end else begin
            w_next_state = ST_IDLE;
          end
        end

        // r_addr is already on the ROM address bus; data arrives in LATCH.
        ST_FETCH: begin
          w_next_state = ST_LATCH;
        end

        ST_LATCH: begin
          if (w_word.is_end) begin
`ifdef SEQ_LOOP_EN
            w_next_state = ST_FETCH;
            w_addr       = r_base;
            w_done       = 1'b1;
`else
            w_next_state = ST_DONE;
            w_done       = 1'b1;
`endif
          end else begin
            w_next_state = ST_PLAY;
            w_en         = 1'b1;
            w_oct        = w_word.octave;
            w_len        = w_word.length;
            w_mask_load  = 1'b1;
            if (w_word.note == NOTE_INVALID) begin
              w_note = {NOTE_BITS{1'b0}};
              w_mute = 1'b1;
            end else begin
              w_note = w_word.note;
              w_mute = w_word.rest;
            end
          end
        end

        ST_PLAY: begin
          if (w_mask_expired && i_snd_over) begin
            w_next_state = ST_GAP;
            w_gap_load   = 1'b1;
          end else begin
            w_next_state = ST_PLAY;
            w_en         = 1'b1;
            w_mute       = r_mute;
          end
        end

        ST_GAP: begin
          if (w_gap_expired) begin
            w_next_state = ST_FETCH;
            w_addr       = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            w_next_state = ST_GAP;
          end
        end

        ST_DONE: begin
          w_next_state = ST_IDLE;
        end

        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_base  <= {ADDR_W{1'b0}};
      r_en    <= 1'b0;
      r_oct   <= {OCTAVE_BITS{1'b0}};
      r_note  <= {NOTE_BITS{1'b0}};
      r_len   <= {LENGTH_BITS{1'b0}};
      r_full  <= {FULL_NOTE_BITS{1'b0}};
      r_mute  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_addr;
      r_base  <= w_base;
      r_en    <= w_en;
      r_oct   <= w_oct;
      r_note  <= w_note;
      r_len   <= w_len;
      r_full  <= w_full;
      r_mute  <= w_mute;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= w_done;
    end
  end

  assign o_rom_addr      = r_addr;
  assign o_snd_en        = r_en;
  assign o_snd_octave    = r_oct;
  assign o_snd_note      = r_note;
  assign o_snd_length    = r_len;
  assign o_snd_full_note = r_full;
  assign o_snd_mute      = r_mute;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
// Purpose : self-checking bench for song_sequencer (ADDR_W=8, GAP_CYCLES=4,
//           OVER_MASK=2). Expected behaviour comes from walking the ROM image
//           note by note and decoding the fields arithmetically.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  localparam int          ADDR_W = 8;
  localparam int unsigned GAP    = 32'd4;
  localparam int unsigned MASK   = 32'd2;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic                      stop;
  logic [ADDR_W-1:0]         song_base;
  logic [FULL_NOTE_BITS-1:0] full_note;
  logic [ADDR_W-1:0]         rom_addr;
  logic [ROM_W-1:0]          rom_data;
  logic                      snd_en;
  logic [OCTAVE_BITS-1:0]    snd_octave;
  logic [NOTE_BITS-1:0]      snd_note;
  logic [LENGTH_BITS-1:0]    snd_length;
  logic [FULL_NOTE_BITS-1:0] snd_full_note;
  logic                      snd_over;
  logic                      snd_mute;
  logic                      busy;
  logic                      done;

  logic [ROM_W-1:0] rom [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  song_sequencer #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .OVER_MASK(MASK)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_stop          (stop),
    .i_song_base     (song_base),
    .i_full_note     (full_note),
    .o_rom_addr      (rom_addr),
    .i_rom_data      (rom_data),
    .o_snd_en        (snd_en),
    .o_snd_octave    (snd_octave),
    .o_snd_note      (snd_note),
    .o_snd_length    (snd_length),
    .o_snd_full_note (snd_full_note),
    .i_snd_over      (snd_over),
    .o_snd_mute      (snd_mute),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   32'(snd_en), 32'd0);
    chk({tag, "_oct"},  32'(snd_octave), 32'd0);
    chk({tag, "_note"}, 32'(snd_note), 32'd0);
    chk({tag, "_len"},  32'(snd_length), 32'd0);
    chk({tag, "_full"}, 32'(snd_full_note), 32'd0);
    chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_mute"}, 32'(snd_mute), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Called in the first PLAY cycle. snd_over goes high from PLAY cycle k on;
  // it is only honoured once MASK cycles have passed, so the note lasts
  // max(k, MASK)+1 cycles, followed by GAP silent cycles.
  task automatic play_note(input logic [ROM_W-1:0] w, input logic [3:0] full,
                           input int k_in, input bit poke_start);
    int k;
    int len_play;
    int e_oct;
    int e_note;
    int e_len;
    int e_mute;
    k        = (k_in < 0) ? int'($urandom_range(0, 5)) : k_in;
    len_play = ((k > int'(MASK)) ? k : int'(MASK)) + 1;
    e_oct    = (int'(w) >> 7) & 7;
    e_note   = (int'(w) >> 4) & 7;
    e_len    = (int'(w) >> 1) & 7;
    e_mute   = (int'(w) >> 10) & 1;
    if (e_note == 7) begin
      e_note = 0;
      e_mute = 1;
    end
    for (int i = 0; i < len_play; i++) begin
      chk("play_en",   32'(snd_en), 32'd1);
      chk("play_oct",  32'(snd_octave), 32'(e_oct));
      chk("play_note", 32'(snd_note), 32'(e_note));
      chk("play_len",  32'(snd_length), 32'(e_len));
      chk("play_mute", 32'(snd_mute), 32'(e_mute));
      chk("play_full", 32'(snd_full_note), 32'(full));
      snd_over = (i >= k);
      if (poke_start) begin
        start     = 1'($urandom_range(0, 1));
        song_base = 8'($urandom);
      end
      tick;
    end
    start = 1'b0;
    for (int g = 0; g < int'(GAP); g++) begin
      chk("gap_en",   32'(snd_en), 32'd0);
      chk("gap_mute", 32'(snd_mute), 32'd1);
      chk("gap_busy", 32'(busy), 32'd1);
      snd_over = 1'($urandom_range(0, 1));
      tick;
    end
    snd_over = 1'b0;
  endtask

  // Plays a song from base to its end marker, checking every cycle.
  task automatic run_song(input logic [7:0] base, input logic [3:0] full,
                          input int k_first, input bit poke_start);
    logic [7:0] a;
    int         k;
    a         = base;
    song_base = base;
    full_note = full;
    start     = 1'b1;
    tick;
    start     = 1'b0;
    full_note = 4'($urandom);
    for (int n = 0; n < 300; n++) begin
      chk("fetch_addr", 32'(rom_addr), 32'(a));
      chk("fetch_en",   32'(snd_en), 32'd0);
      chk("fetch_busy", 32'(busy), 32'd1);
      tick;
      chk("latch_en",   32'(snd_en), 32'd0);
      if (rom[a][11]) break;
      tick;
      k = (n == 0) ? k_first : -1;
      play_note(rom[a], full, k, poke_start);
      a = a + 8'd1;
    end
    tick;
    if (LOOP) begin
      chk("wrap_addr", 32'(rom_addr), 32'(base));
      chk("wrap_done", 32'(done), 32'd1);
      chk("wrap_busy", 32'(busy), 32'd1);
      tick;
      chk("wrap_done_pulse", 32'(done), 32'd0);
      stop = 1'b1;
      tick;
      stop = 1'b0;
      chk("wrap_stop_busy", 32'(busy), 32'd0);
      chk("wrap_stop_done", 32'(done), 32'd0);
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy",  32'(busy), 32'd1);
      chk("done_en",    32'(snd_en), 32'd0);
      tick;
      chk("idle_done",  32'(done), 32'd0);
      chk("idle_busy",  32'(busy), 32'd0);
      chk("idle_mute",  32'(snd_mute), 32'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    song_base = 8'd0;
    full_note = 4'd0;
    snd_over  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'h800;
    rom[0]   = {1'b0, 1'b0, 3'd4, 3'd0, 3'd2, 1'b0};
    rom[10]  = {1'b0, 1'b1, 3'd5, 3'd3, 3'd1, 1'b0};
    rom[11]  = {1'b0, 1'b0, 3'd2, 3'd6, 3'd0, 1'b1};
    rom[12]  = {1'b0, 1'b0, 3'd7, 3'd7, 3'd6, 1'b0};
    rom[255] = {1'b0, 1'b0, 3'd3, 3'd1, 3'd3, 1'b0};
    for (int i = 50; i < 56; i++) rom[i] = 12'($urandom) & 12'h7FF;

    tick;
    tick;
    chk_reset("reset");
    rst_n = 1'b1;
    tick;
    chk("idle_busy0", 32'(busy), 32'd0);

    // Basic one-note song, snd_over already high at PLAY entry.
    run_song(8'd0, 4'd1, 0, 1'b0);
    // Rest, normal note (reserved bit set), invalid note.
    run_song(8'd10, 4'd9, -1, 1'b0);
    // Address wrap from 255 to 0.
    run_song(8'd255, 4'd3, 3, 1'b0);
    // Random notes, with start pokes while busy.
    run_song(8'd50, 4'd12, -1, 1'b1);

    // stop together with snd_over and start in mid-PLAY.
    song_base = 8'd0;
    full_note = 4'd5;
    start     = 1'b1;
    tick;
    start     = 1'b0;
    tick;
    tick;
    chk("stop_pre_en", 32'(snd_en), 32'd1);
    tick;
    tick;
    stop     = 1'b1;
    snd_over = 1'b1;
    start    = 1'b1;
    tick;
    chk("stop_en",   32'(snd_en), 32'd0);
    chk("stop_mute", 32'(snd_mute), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    tick;
    stop     = 1'b0;
    start    = 1'b0;
    snd_over = 1'b0;
    chk("stop_start_busy", 32'(busy), 32'd0);
    tick;
    chk("stop_after_busy", 32'(busy), 32'd0);
    chk("stop_after_done", 32'(done), 32'd0);

    // Reset in the middle of a note.
    song_base = 8'd50;
    full_note = 4'd7;
    start     = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick;
    chk_reset("midreset");
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
